// File: rtl/mc_rr_arbiter.sv
// mc_rr_arbiter
//   Shares one memory-controller port between CONNECT_NUM requesters.
//   Grants are round-robin, and a stalled grant stays locked until it
//   completes. Each accepted request pushes its requester index into an
//   in-order tag FIFO. The FIFO head routes each response back to the
//   requester that issued it. Both directions are zero-cycle combinational.
//
// Ports
//   CLK, RST                  clock, synchronous active-high reset
//   SLAVE_RECEIVE_*           per-requester request side (slice i = requester i)
//   SLAVE_SEND_*              per-requester response side
//   MASTER_SEND_*             request to the memory controller
//   MASTER_RECEIVE_*          response from the memory controller
module mc_rr_arbiter #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int CONNECT_NUM = 3,
    parameter int DEPTH       = 4
) (
    input  logic                              CLK,
    input  logic                              RST,
    input  logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_ADDR_VALID,
    input  logic [ADDR_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_ADDR,
    input  logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_DATA_VALID,
    input  logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_RECEIVE_DATA,
    output logic [CONNECT_NUM-1:0]            SLAVE_RECEIVE_READY,
    output logic [CONNECT_NUM-1:0]            SLAVE_SEND_VALID,
    output logic [DATA_WIDTH*CONNECT_NUM-1:0] SLAVE_SEND_DATA,
    input  logic [CONNECT_NUM-1:0]            SLAVE_SEND_READY,
    output logic                              MASTER_SEND_ADDR_VALID,
    output logic [ADDR_WIDTH-1:0]             MASTER_SEND_ADDR,
    output logic                              MASTER_SEND_DATA_VALID,
    output logic [DATA_WIDTH-1:0]             MASTER_SEND_DATA,
    input  logic                              MASTER_SEND_READY,
    input  logic                              MASTER_RECEIVE_VALID,
    input  logic [DATA_WIDTH-1:0]             MASTER_RECEIVE_DATA,
    output logic                              MASTER_RECEIVE_READY
);

    localparam int IDX_W = (CONNECT_NUM > 1) ? $clog2(CONNECT_NUM) : 1;
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [IDX_W-1:0] rr_ptr, lock_idx, rr_gnt, grant, grant_nxt, head;
    logic             lock;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    logic [IDX_W-1:0] tag_mem [DEPTH];
    logic             full, empty, push, pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // Round-robin search starting at rr_ptr. The loop runs from the farthest
    // offset to the nearest, so the requester closest to rr_ptr is assigned last.
    always_comb begin
        int               cand;
        logic [IDX_W-1:0] cand_idx;
        rr_gnt   = rr_ptr;
        cand     = 0;
        cand_idx = '0;
        for (int k = CONNECT_NUM - 1; k >= 0; k--) begin
            cand = int'(rr_ptr) + k;
            if (cand >= CONNECT_NUM) cand = cand - CONNECT_NUM;
            cand_idx = IDX_W'(cand);
            if (SLAVE_RECEIVE_ADDR_VALID[cand_idx]) rr_gnt = cand_idx;
        end
    end

    assign grant     = lock ? lock_idx : rr_gnt;
    assign grant_nxt = (grant == IDX_W'(CONNECT_NUM - 1)) ? '0 : grant + IDX_W'(1);

    // A full FIFO blocks the push even when a pop happens in the same cycle.
    // This keeps the FIFO ready path off the response handshake.
    assign MASTER_SEND_ADDR_VALID = SLAVE_RECEIVE_ADDR_VALID[grant] && !full;
    assign MASTER_SEND_ADDR       = SLAVE_RECEIVE_ADDR[grant*ADDR_WIDTH +: ADDR_WIDTH];
    assign MASTER_SEND_DATA       = SLAVE_RECEIVE_DATA[grant*DATA_WIDTH +: DATA_WIDTH];
    assign MASTER_SEND_DATA_VALID = SLAVE_RECEIVE_DATA_VALID[grant];
    assign push                   = MASTER_SEND_ADDR_VALID && MASTER_SEND_READY;

    always_comb begin
        SLAVE_RECEIVE_READY = '0;
        if (push) SLAVE_RECEIVE_READY[grant] = 1'b1;
    end

    // Response routing: the head tag selects which requester sees the response.
    assign head                 = tag_mem[rd_ptr];
    assign MASTER_RECEIVE_READY = !empty && SLAVE_SEND_READY[head];
    assign pop                  = MASTER_RECEIVE_VALID && MASTER_RECEIVE_READY;
    assign SLAVE_SEND_DATA      = {CONNECT_NUM{MASTER_RECEIVE_DATA}};

    always_comb begin
        SLAVE_SEND_VALID = '0;
        if (!empty) SLAVE_SEND_VALID[head] = MASTER_RECEIVE_VALID;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            rr_ptr   <= '0;
            lock     <= 1'b0;
            lock_idx <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
        end else begin
            if (push) begin
                rr_ptr <= grant_nxt;
                lock   <= 1'b0;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end else if (MASTER_SEND_ADDR_VALID) begin
                // Stalled by the controller: hold this grant until it completes.
                lock     <= 1'b1;
                lock_idx <= grant;
            end else if (lock && !SLAVE_RECEIVE_ADDR_VALID[lock_idx]) begin
                // The locked requester withdrew its request; re-arbitrate.
                lock <= 1'b0;
            end
            if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Tag storage needs no reset: entries are only read behind a valid count.
    always_ff @(posedge CLK) begin
        if (push) tag_mem[wr_ptr] <= grant;
    end

endmodule

// File: tb/tb_mc_rr_arbiter.sv
module tb_mc_rr_arbiter;
    localparam int AW = 32, DW = 32, N = 3, D = 4;

    logic            CLK, RST;
    logic [N-1:0]    av, dv, srr, ssv, ssr;
    logic [AW*N-1:0] saddr;
    logic [DW*N-1:0] sdata, ssdata;
    logic            mav, mdv, msr, mrv, mrr;
    logic [AW-1:0]   maddr;
    logic [DW-1:0]   mdata, mrd;

    mc_rr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CONNECT_NUM(N), .DEPTH(D)) dut (
        .CLK(CLK), .RST(RST),
        .SLAVE_RECEIVE_ADDR_VALID(av), .SLAVE_RECEIVE_ADDR(saddr),
        .SLAVE_RECEIVE_DATA_VALID(dv), .SLAVE_RECEIVE_DATA(sdata),
        .SLAVE_RECEIVE_READY(srr), .SLAVE_SEND_VALID(ssv),
        .SLAVE_SEND_DATA(ssdata), .SLAVE_SEND_READY(ssr),
        .MASTER_SEND_ADDR_VALID(mav), .MASTER_SEND_ADDR(maddr),
        .MASTER_SEND_DATA_VALID(mdv), .MASTER_SEND_DATA(mdata),
        .MASTER_SEND_READY(msr), .MASTER_RECEIVE_VALID(mrv),
        .MASTER_RECEIVE_DATA(mrd), .MASTER_RECEIVE_READY(mrr)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [2:0]  av;
        logic        msr;
        logic        mrv;
        logic [31:0] mrd;
        logic [2:0]  ssr;
        logic [2:0]  e_srr;
        logic        e_mav;
        int          e_gnt;
        logic [2:0]  e_ssv;
        logic        e_mrr;
    } vec_t;

    vec_t        tv [$];
    int          checks = 0;
    int          errors = 0;
    logic [2:0]  dv_pat = 3'b101;

    function automatic vec_t mk(logic r, logic [2:0] a, logic ms, logic mv, logic [31:0] md,
                                logic [2:0] sr, logic [2:0] esrr, logic emav, int eg,
                                logic [2:0] essv, logic emrr);
        vec_t v;
        v.rst = r; v.av = a; v.msr = ms; v.mrv = mv; v.mrd = md; v.ssr = sr;
        v.e_srr = esrr; v.e_mav = emav; v.e_gnt = eg; v.e_ssv = essv; v.e_mrr = emrr;
        return v;
    endfunction

    task automatic chk(string name, int idx, logic [95:0] act, logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        end
    endtask

    // Requester i presents address 0x100*i and data 0xD000+i.
    task automatic drive(logic r, logic [2:0] a, logic ms, logic mv, logic [31:0] md, logic [2:0] sr);
        RST = r; av = a; msr = ms; mrv = mv; mrd = md; ssr = sr;
    endtask

    task automatic check_vec(int i, vec_t v);
        chk("srv_ready", i, 96'(srr), 96'(v.e_srr));
        chk("mst_addr_valid", i, 96'(mav), 96'(v.e_mav));
        if (v.e_mav) begin
            chk("mst_addr", i, 96'(maddr), 96'(32'h100 * v.e_gnt));
            chk("mst_data", i, 96'(mdata), 96'(32'hD000 + v.e_gnt));
            chk("mst_data_valid", i, 96'(mdv), 96'(dv_pat[v.e_gnt]));
        end
        chk("slv_send_valid", i, 96'(ssv), 96'(v.e_ssv));
        chk("mst_recv_ready", i, 96'(mrr), 96'(v.e_mrr));
        chk("slv_send_data", i, ssdata, {3{v.mrd}});
    endtask

    initial begin
        for (int i = 0; i < N; i++) begin
            saddr[i*AW +: AW] = 32'h100 * i;
            sdata[i*DW +: DW] = 32'hD000 + i;
        end
        dv = dv_pat;
        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 3'b000);
        @(posedge CLK); @(posedge CLK);

        //          rst av      msr mrv mrd        ssr     srr     mav gnt ssv     mrr
        tv.push_back(mk(0, 3'b000, 0, 0, 32'h0,    3'b000, 3'b000, 0, 0, 3'b000, 0)); // 0 reset state
        tv.push_back(mk(0, 3'b010, 1, 0, 32'h0,    3'b000, 3'b010, 1, 1, 3'b000, 0)); // 1 single req1
        tv.push_back(mk(0, 3'b000, 0, 1, 32'hCAFE, 3'b111, 3'b000, 0, 0, 3'b010, 1)); // 2 resp to req1
        tv.push_back(mk(0, 3'b000, 0, 1, 32'hBEEF, 3'b111, 3'b000, 0, 0, 3'b000, 0)); // 3 empty: hold resp
        tv.push_back(mk(1, 3'b000, 0, 0, 32'h0,    3'b000, 3'b000, 0, 0, 3'b000, 0)); // 4 reset
        tv.push_back(mk(0, 3'b111, 1, 0, 32'h0,    3'b000, 3'b001, 1, 0, 3'b000, 0)); // 5 rr grant 0
        tv.push_back(mk(0, 3'b111, 1, 0, 32'h0,    3'b000, 3'b010, 1, 1, 3'b000, 0)); // 6 grant 1
        tv.push_back(mk(0, 3'b111, 1, 0, 32'h0,    3'b000, 3'b100, 1, 2, 3'b000, 0)); // 7 grant 2
        tv.push_back(mk(0, 3'b111, 1, 0, 32'h0,    3'b000, 3'b001, 1, 0, 3'b000, 0)); // 8 grant 0, full
        tv.push_back(mk(0, 3'b111, 1, 0, 32'h0,    3'b000, 3'b000, 0, 0, 3'b000, 0)); // 9 full blocks
        tv.push_back(mk(0, 3'b111, 1, 1, 32'h1111, 3'b111, 3'b000, 0, 0, 3'b001, 1)); // 10 full + pop: no push
        tv.push_back(mk(0, 3'b111, 1, 0, 32'h0,    3'b000, 3'b010, 1, 1, 3'b000, 0)); // 11 push next cycle
        tv.push_back(mk(0, 3'b111, 1, 0, 32'h0,    3'b000, 3'b000, 0, 0, 3'b000, 0)); // 12 full again
        tv.push_back(mk(0, 3'b000, 0, 1, 32'h2222, 3'b111, 3'b000, 0, 0, 3'b010, 1)); // 13 pop tag1
        tv.push_back(mk(0, 3'b000, 0, 1, 32'h3333, 3'b011, 3'b000, 0, 0, 3'b100, 0)); // 14 head 2 backpressure
        tv.push_back(mk(0, 3'b000, 0, 1, 32'h3333, 3'b011, 3'b000, 0, 0, 3'b100, 0)); // 15 still held
        tv.push_back(mk(0, 3'b000, 0, 1, 32'h3333, 3'b100, 3'b000, 0, 0, 3'b100, 1)); // 16 pop to req2
        tv.push_back(mk(0, 3'b010, 0, 0, 32'h0,    3'b000, 3'b000, 1, 1, 3'b000, 0)); // 17 req1 stalled
        tv.push_back(mk(0, 3'b011, 0, 0, 32'h0,    3'b000, 3'b000, 1, 1, 3'b000, 0)); // 18 locked vs req0
        tv.push_back(mk(0, 3'b011, 0, 0, 32'h0,    3'b000, 3'b000, 1, 1, 3'b000, 0)); // 19 still locked
        tv.push_back(mk(0, 3'b011, 1, 0, 32'h0,    3'b000, 3'b010, 1, 1, 3'b000, 0)); // 20 req1 accepted
        tv.push_back(mk(0, 3'b101, 1, 0, 32'h0,    3'b000, 3'b100, 1, 2, 3'b000, 0)); // 21 next grant 2
        tv.push_back(mk(0, 3'b000, 0, 1, 32'h4444, 3'b111, 3'b000, 0, 0, 3'b001, 1)); // 22 pop tag0, 3 left
        tv.push_back(mk(1, 3'b000, 0, 0, 32'h0,    3'b000, 3'b000, 0, 0, 3'b000, 0)); // 23 reset mid-op
        tv.push_back(mk(0, 3'b000, 0, 1, 32'h5555, 3'b111, 3'b000, 0, 0, 3'b000, 0)); // 24 tags discarded
        tv.push_back(mk(0, 3'b110, 1, 0, 32'h0,    3'b000, 3'b010, 1, 1, 3'b000, 0)); // 25 rr from 0
        tv.push_back(mk(0, 3'b100, 0, 0, 32'h0,    3'b000, 3'b000, 1, 2, 3'b000, 0)); // 26 lock req2
        tv.push_back(mk(0, 3'b001, 0, 0, 32'h0,    3'b000, 3'b000, 0, 0, 3'b000, 0)); // 27 req2 drops
        tv.push_back(mk(0, 3'b011, 1, 0, 32'h0,    3'b000, 3'b001, 1, 0, 3'b000, 0)); // 28 re-arbitrated

        foreach (tv[i]) begin
            @(negedge CLK);
            drive(tv[i].rst, tv[i].av, tv[i].msr, tv[i].mrv, tv[i].mrd, tv[i].ssr);
            #1;
            check_vec(i, tv[i]);
        end

        // Back-to-back: one push and one pop every cycle. The occupancy stays
        // at one, and grants and responses rotate together through 0,1,2.
        @(negedge CLK);
        drive(1'b1, 3'b000, 1'b0, 1'b0, 32'h0, 3'b000);
        for (int k = 0; k < 6; k++) begin
            logic [2:0] e_srr, e_ssv;
            @(negedge CLK);
            drive(1'b0, 3'b111, 1'b1, 1'b1, 32'h7000 + k, 3'b111);
            #1;
            e_srr = 3'b001 << (k % 3);
            e_ssv = (k == 0) ? 3'b000 : (3'b001 << ((k - 1) % 3));
            chk("b2b_srv_ready", 100 + k, 96'(srr), 96'(e_srr));
            chk("b2b_slv_send_valid", 100 + k, 96'(ssv), 96'(e_ssv));
            chk("b2b_mst_recv_ready", 100 + k, 96'(mrr), 96'(k != 0));
        end

        @(negedge CLK);
        drive(1'b0, 3'b000, 1'b0, 1'b0, 32'h0, 3'b000);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mc_rr_arbiter.md
Name: mc_rr_arbiter

Overview:
- Shares one memory-controller port between CONNECT_NUM requesters.
- Uses round-robin arbitration and allows up to DEPTH outstanding requests.
- Each accepted request is tagged with its requester index in an in-order tag FIFO, so responses return to the correct requester.
- Sits between the requester-side slave ports and the single master port of the memory controller.
- Every request yields exactly one response, in issue order.

Parameters:
ADDR_WIDTH, 32, address width per request
DATA_WIDTH, 32, data width of request data and response data
CONNECT_NUM, 3, number of requesters (>=2)
DEPTH, 4, max outstanding requests; power of two, >=2

Ports:
CLK  in  1  clock
RST  in  1  reset
SLAVE_RECEIVE_ADDR_VALID  in  CONNECT_NUM  per-requester request valid
SLAVE_RECEIVE_ADDR  in  ADDR_WIDTH*CONNECT_NUM  request address, slice i = requester i
SLAVE_RECEIVE_DATA_VALID  in  CONNECT_NUM  request carries write data
SLAVE_RECEIVE_DATA  in  DATA_WIDTH*CONNECT_NUM  request write data
SLAVE_RECEIVE_READY  out  CONNECT_NUM  request accepted (one-hot or zero)
SLAVE_SEND_VALID  out  CONNECT_NUM  response valid to requester (one-hot or zero)
SLAVE_SEND_DATA  out  DATA_WIDTH*CONNECT_NUM  response data; every slice = MASTER_RECEIVE_DATA
SLAVE_SEND_READY  in  CONNECT_NUM  requester accepts response
MASTER_SEND_ADDR_VALID  out  1  request valid to controller
MASTER_SEND_ADDR  out  ADDR_WIDTH  granted requester's address
MASTER_SEND_DATA_VALID  out  1  granted requester's DATA_VALID
MASTER_SEND_DATA  out  DATA_WIDTH  granted requester's data
MASTER_SEND_READY  in  1  controller accepts request
MASTER_RECEIVE_VALID  in  1  response valid from controller
MASTER_RECEIVE_DATA  in  DATA_WIDTH  response data
MASTER_RECEIVE_READY  out  1  response accepted

Behaviour:
- Clock and reset: single clock CLK; RST is synchronous and active-high.
- Reset state: rr_ptr=0; lock=0; tag FIFO empty (count=0, rd/wr ptr=0).
- Outputs after reset: all outputs are combinational from state and inputs. With inputs idle, every VALID/READY output is 0.
- Grant selection:
  - When lock=0: grant = first i with ADDR_VALID[i], searching rr_ptr, rr_ptr+1, ... mod CONNECT_NUM.
  - When lock=1: grant = lock_idx.
- Request valid: MASTER_SEND_ADDR_VALID = ADDR_VALID[grant] && !full.
  - MASTER_SEND_ADDR, MASTER_SEND_DATA and MASTER_SEND_DATA_VALID carry slice `grant`.
  - These are don't-care when valid=0.
- Request accept: SLAVE_RECEIVE_READY[grant] = MASTER_SEND_READY && MASTER_SEND_ADDR_VALID; all other bits are 0.
- Request handshake (MASTER_SEND_ADDR_VALID && MASTER_SEND_READY):
  - push grant into tag FIFO;
  - rr_ptr <= (grant+1) mod CONNECT_NUM;
  - lock <= 0.
- Lock on stall:
  - If MASTER_SEND_ADDR_VALID && !MASTER_SEND_READY: lock <= 1, lock_idx <= grant.
  - Address and data stay stable until the handshake; new higher-priority requests do not steal the grant.
- Locked requester drops valid: lock <= 0 and arbitration restarts next cycle. This is a protocol violation, but it must not hang.
- Full (count==DEPTH):
  - MASTER_SEND_ADDR_VALID=0 and all SLAVE_RECEIVE_READY=0.
  - A pop in the same cycle does not enable a push; the push waits one cycle.
- Response path, FIFO non-empty (head = FIFO[rd_ptr]):
  - SLAVE_SEND_VALID[head] = MASTER_RECEIVE_VALID; all other bits are 0.
  - MASTER_RECEIVE_READY = SLAVE_SEND_READY[head].
- Response path, FIFO empty: SLAVE_SEND_VALID=0 and MASTER_RECEIVE_READY=0, so the controller holds its response.
- Response handshake (MASTER_RECEIVE_VALID && MASTER_RECEIVE_READY): pop one tag.
- Count update:
  - push only: count+1;
  - pop only: count-1;
  - push and pop in the same cycle: count unchanged; pointers each advance mod DEPTH.
- Latency: zero-cycle combinational forwarding in both directions. Accepted request throughput is 1 per cycle.
- Reset mid-operation: all outstanding tags are discarded. The system resets the controller together with this block.

Test Plan:
- Single requester: req1 raises ADDR_VALID with ADDR=0x100; MASTER_SEND_READY=1 -> MASTER_SEND_ADDR=0x100 and SLAVE_RECEIVE_READY=3'b010 in the same cycle. Response 0xCAFE -> SLAVE_SEND_VALID=3'b010, data 0xCAFE; count returns to 0.
- Round-robin: all 3 requesters valid continuously, MASTER_SEND_READY=1 -> grants 0,1,2,0 on consecutive cycles. FIFO full after 4 accepts; MASTER_SEND_ADDR_VALID=0 on cycle 5.
- Stall lock: req1 granted with MASTER_SEND_READY=0 for 3 cycles; req0 raises valid in cycle 2 -> grant stays 1 and ADDR is stable. Ready=1 -> req1 accepted, next grant is 2 (if valid), else 0.
- Full with same-cycle pop: DEPTH=4 full, response handshake and a pending request in the same cycle -> no push that cycle. Push occurs the next cycle, count=4 again.
- Response backpressure: head tag=2, MASTER_RECEIVE_VALID=1, SLAVE_SEND_READY[2]=0 for 2 cycles -> MASTER_RECEIVE_READY=0 and no pop. On ready=1, the pop occurs and the response goes only to req2.
- Reset mid-operation: 3 tags outstanding, RST pulsed 1 cycle -> count=0, rr_ptr=0, all VALID/READY outputs 0. MASTER_RECEIVE_VALID=1 afterwards -> MASTER_RECEIVE_READY=0.
